// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - board geometry, 640x480 VGA timing constants and the RGB332 colour type
package tetris_pkg;

  localparam int BOARD_COLS  = 10;
  localparam int BOARD_ROWS  = 20;
  localparam int BOARD_CELLS = BOARD_COLS * BOARD_ROWS;

  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] H_FP    = 10'd16;
  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] H_BP    = 10'd48;
  localparam logic [9:0] H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] V_FP    = 10'd10;
  localparam logic [9:0] V_SYNC  = 10'd2;
  localparam logic [9:0] V_BP    = 10'd33;
  localparam logic [9:0] V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  typedef logic [7:0] rgb332_t;

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel-enable divider, h/v scan counters and raw sync/visible flags
module vga_timing
  import tetris_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       pe_o,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       hs_raw_o,
  output logic       vs_raw_o,
  output logic       vis_o
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             pe;
  logic             h_last;

  assign pe     = (div_q == DIV_LAST);
  assign h_last = (h_q == H_TOTAL - 10'd1);

  always_comb begin
    div_d = pe ? '0 : div_q + DIV_W'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (pe) begin
      h_d = h_last ? 10'd0 : h_q + 10'd1;
      if (h_last) begin
        v_d = (v_q == V_TOTAL - 10'd1) ? 10'd0 : v_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      h_q   <= 10'd0;
      v_q   <= 10'd0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign pe_o     = pe;
  assign h_o      = h_q;
  assign v_o      = v_q;
  assign hs_raw_o = !((h_q >= H_VIS + H_FP) && (h_q < H_VIS + H_FP + H_SYNC));
  assign vs_raw_o = !((v_q >= V_VIS + V_FP) && (v_q < V_VIS + V_FP + V_SYNC));
  assign vis_o    = (h_q < H_VIS) && (v_q < V_VIS);

endmodule

// File: rtl/tetris_vga_renderer.sv
// rtl/tetris_vga_renderer.sv - draws a per-frame snapshot of the 10x20 board; TETRIS_GRID_EN adds grey cell grid lines
module tetris_vga_renderer
  import tetris_pkg::*;
#(
  parameter int      CLK_DIV    = 4,
  parameter int      BOARD_X    = 240,
  parameter int      BOARD_Y    = 80,
  parameter int      CELL_SHIFT = 4,
  parameter rgb332_t FILL_RGB   = 8'hFC,
  parameter rgb332_t EMPTY_RGB  = 8'h00,
  parameter rgb332_t BG_RGB     = 8'h25
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [BOARD_CELLS-1:0] blocks,
  output logic                   hsync,
  output logic                   vsync,
  output rgb332_t                vga_rgb,
  output logic                   frame_tick
);

  localparam int BOARD_W = BOARD_COLS << CELL_SHIFT;
  localparam int BOARD_H = BOARD_ROWS << CELL_SHIFT;

  if ((BOARD_X < 0) || (BOARD_Y < 0) ||
      (BOARD_X + BOARD_W > int'(H_VIS)) || (BOARD_Y + BOARD_H > int'(V_VIS))) begin : g_geometry_check
    $error("tetris_vga_renderer: playfield does not fit inside the 640x480 visible area");
  end

  localparam logic [9:0] BX     = 10'(BOARD_X);
  localparam logic [9:0] BY     = 10'(BOARD_Y);
  localparam logic [9:0] BX_END = 10'(BOARD_X + BOARD_W);
  localparam logic [9:0] BY_END = 10'(BOARD_Y + BOARD_H);

  logic       pe, hs_raw, vs_raw, vis;
  logic [9:0] h, v;

  vga_timing #(
    .CLK_DIV (CLK_DIV)
  ) u_timing (
    .clk_i    (Clk),
    .rst_ni   (Reset),
    .pe_o     (pe),
    .h_o      (h),
    .v_o      (v),
    .hs_raw_o (hs_raw),
    .vs_raw_o (vs_raw),
    .vis_o    (vis)
  );

  // Board is latched only at the first pe of vertical blank so a frame never tears.
  logic                   snap_take;
  logic [BOARD_CELLS-1:0] snap_q;
  logic                   frame_tick_q;

  assign snap_take = pe && (h == 10'd0) && (v == V_VIS);

  logic [9:0] x_off, y_off;
  logic [3:0] col;
  logic [4:0] srow, row;
  logic [7:0] row8, idx_d;
  logic       in_board_d;

  assign x_off      = h - BX;
  assign y_off      = v - BY;
  assign in_board_d = (h >= BX) && (h < BX_END) && (v >= BY) && (v < BY_END);
  assign col        = 4'(x_off >> CELL_SHIFT);
  assign srow       = 5'(y_off >> CELL_SHIFT);
  assign row        = 5'(BOARD_ROWS - 1) - srow;
  assign row8       = {3'b000, row};
  assign idx_d      = in_board_d ? (row8 << 3) + (row8 << 1) + {4'b0000, col} : 8'd0;

`ifdef TETRIS_GRID_EN
  localparam logic [9:0] CELL_MASK = 10'((1 << CELL_SHIFT) - 1);
  localparam rgb332_t    GRID_RGB  = 8'h49;

  logic grid_d, grid1_q;

  assign grid_d = in_board_d &&
                  (((x_off & CELL_MASK) == 10'd0) || ((y_off & CELL_MASK) == 10'd0) ||
                   (h == BX_END - 10'd1) || (v == BY_END - 10'd1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      grid1_q <= 1'b0;
    end else if (pe) begin
      grid1_q <= grid_d;
    end
  end
`endif

  logic       vis1_q, inb1_q, hs1_q, vs1_q;
  logic [7:0] idx1_q;
  rgb332_t    rgb_d, rgb_q;
  logic       hs2_q, vs2_q;

  always_comb begin
    rgb_d = EMPTY_RGB;
    if (!vis1_q) begin
      rgb_d = 8'h00;
    end else if (!inb1_q) begin
      rgb_d = BG_RGB;
`ifdef TETRIS_GRID_EN
    end else if (grid1_q) begin
      rgb_d = GRID_RGB;
`endif
    end else if (snap_q[idx1_q]) begin
      rgb_d = FILL_RGB;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      snap_q       <= '0;
      frame_tick_q <= 1'b0;
      vis1_q       <= 1'b0;
      inb1_q       <= 1'b0;
      idx1_q       <= 8'd0;
      hs1_q        <= 1'b1;
      vs1_q        <= 1'b1;
      rgb_q        <= 8'h00;
      hs2_q        <= 1'b1;
      vs2_q        <= 1'b1;
    end else begin
      frame_tick_q <= snap_take;
      if (snap_take) begin
        snap_q <= blocks;
      end
      if (pe) begin
        vis1_q <= vis;
        inb1_q <= in_board_d;
        idx1_q <= idx_d;
        hs1_q  <= hs_raw;
        vs1_q  <= vs_raw;
        rgb_q  <= rgb_d;
        hs2_q  <= hs1_q;
        vs2_q  <= vs1_q;
      end
    end
  end

  assign hsync      = hs2_q;
  assign vsync      = vs2_q;
  assign vga_rgb    = rgb_q;
  assign frame_tick = frame_tick_q;

endmodule
